// File: rtl/keypad_pkg.sv
// Shared types, constants and row/column helpers for the hex keypad scanner.
// Columns and rows are both active-low, so the helpers work on "exactly one bit low" patterns.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN         = 2'd0,
      DEBOUNCE     = 2'd1,
      WAIT_RELEASE = 2'd2
   } scan_state_t;

   localparam logic [3:0] COL_INIT  = 4'b1110;
   localparam logic [3:0] ROWS_IDLE = 4'hF;

   function automatic logic single_low(input logic [3:0] v);
      logic r;
      case (v)
         4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] v);
      logic [1:0] r;
      case (v)
         4'b1110: r = 2'd0;
         4'b1101: r = 2'd1;
         4'b1011: r = 2'd2;
         4'b0111: r = 2'd3;
         default: r = 2'd0;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] rotate_col(input logic [3:0] v);
      return {v[2:0], v[3]};
   endfunction

endpackage

// File: rtl/keypad_decoder.sv
// Maps a keypad position (row index, column index) to the hex digit printed on that key.
module keypad_decoder
   import keypad_pkg::*;
(
   input  logic [1:0] row_idx,
   input  logic [1:0] col_idx,
   output logic [3:0] digit
);

   // Key legend lookup, column 0 is the leftmost key of each row
   always_comb begin
      digit = 4'h0;
      case ({row_idx, col_idx})
         4'b00_00: digit = 4'h1;
         4'b00_01: digit = 4'h2;
         4'b00_10: digit = 4'h3;
         4'b00_11: digit = 4'hA;
         4'b01_00: digit = 4'h4;
         4'b01_01: digit = 4'h5;
         4'b01_10: digit = 4'h6;
         4'b01_11: digit = 4'hB;
         4'b10_00: digit = 4'h7;
         4'b10_01: digit = 4'h8;
         4'b10_10: digit = 4'h9;
         4'b10_11: digit = 4'hC;
         4'b11_00: digit = 4'h0;
         4'b11_01: digit = 4'hF;
         4'b11_10: digit = 4'hE;
         4'b11_11: digit = 4'hD;
         default:  digit = 4'h0;
      endcase
   end

endmodule

// File: rtl/hex_keypad_scanner.sv
// Scans a 4x4 hex keypad column by column, debounces presses and releases,
// and shifts each accepted digit into a value register for the display driver.
module hex_keypad_scanner
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4,
   parameter int NUM_DIGITS     = 8
) (
   input  logic                    system_clock,
   input  logic                    cpu_rst,
   input  logic                    clock_enable,
   input  logic [3:0]              row_in,
   input  logic                    clear_value,
   output logic [3:0]              col_out,
   output logic                    key_valid,
   output logic [3:0]              key_code,
   output logic [4*NUM_DIGITS-1:0] value_out
);

   localparam int         VW        = 4 * NUM_DIGITS;
   localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_SCANS);

   logic [3:0]  row_meta_r;
   logic [3:0]  row_sync_r;
   scan_state_t state_r, state_nxt_s;
   logic [3:0]  cnt_r, cnt_nxt_s, cnt_inc_s;
   logic [3:0]  col_r, col_nxt_s;
   logic [3:0]  row_lat_r, row_lat_nxt_s;
   logic        accept_s;
   logic        press_s;
   logic [3:0]  digit_s;
   logic        key_valid_r;
   logic [3:0]  key_code_r;
   logic [VW-1:0] value_r;

   assign press_s   = single_low(row_sync_r);
   assign cnt_inc_s = (cnt_r == 4'hF) ? 4'hF : (cnt_r + 4'd1);

   // Two-flop synchroniser for the asynchronous keypad rows
   always_ff @(posedge system_clock or posedge cpu_rst) begin
      if (cpu_rst) begin
         row_meta_r <= ROWS_IDLE;
         row_sync_r <= ROWS_IDLE;
      end else begin
         row_meta_r <= row_in;
         row_sync_r <= row_meta_r;
      end
   end

   keypad_decoder u_decoder (
      .row_idx (low_index(row_sync_r)),
      .col_idx (low_index(col_r)),
      .digit   (digit_s)
   );

   // Scan FSM state, debounce counter, column drive and latched row pattern
   always_ff @(posedge system_clock or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_r   <= SCAN;
         cnt_r     <= 4'd0;
         col_r     <= COL_INIT;
         row_lat_r <= ROWS_IDLE;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         col_r     <= col_nxt_s;
         row_lat_r <= row_lat_nxt_s;
      end
   end

   // Next-state logic; rows are judged against the column driven since the previous tick
   always_comb begin
      state_nxt_s   = state_r;
      cnt_nxt_s     = cnt_r;
      col_nxt_s     = col_r;
      row_lat_nxt_s = row_lat_r;
      accept_s      = 1'b0;
      if (clock_enable) begin
         case (state_r)
            SCAN: begin
               if (press_s) begin
                  row_lat_nxt_s = row_sync_r;
                  if (DEB_LIMIT <= 4'd1) begin
                     accept_s    = 1'b1;
                     cnt_nxt_s   = 4'd0;
                     state_nxt_s = WAIT_RELEASE;
                  end else begin
                     cnt_nxt_s   = 4'd1;
                     state_nxt_s = DEBOUNCE;
                  end
               end else begin
                  col_nxt_s = rotate_col(col_r);
               end
            end
            DEBOUNCE: begin
               if (row_sync_r == row_lat_r) begin
                  if (cnt_inc_s >= DEB_LIMIT) begin
                     accept_s    = 1'b1;
                     cnt_nxt_s   = 4'd0;
                     state_nxt_s = WAIT_RELEASE;
                  end else begin
                     cnt_nxt_s = cnt_inc_s;
                  end
               end else begin
                  cnt_nxt_s   = 4'd0;
                  col_nxt_s   = rotate_col(col_r);
                  state_nxt_s = SCAN;
               end
            end
            WAIT_RELEASE: begin
               if (row_sync_r == ROWS_IDLE) begin
                  if (cnt_inc_s >= DEB_LIMIT) begin
                     cnt_nxt_s   = 4'd0;
                     col_nxt_s   = rotate_col(col_r);
                     state_nxt_s = SCAN;
                  end else begin
                     cnt_nxt_s = cnt_inc_s;
                  end
               end else begin
                  cnt_nxt_s = 4'd0;
               end
            end
            default: begin
               cnt_nxt_s   = 4'd0;
               col_nxt_s   = COL_INIT;
               state_nxt_s = SCAN;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Registered accept outputs; a coincident clear keeps only the new digit
   always_ff @(posedge system_clock or posedge cpu_rst) begin
      if (cpu_rst) begin
         key_valid_r <= 1'b0;
         key_code_r  <= 4'h0;
         value_r     <= {VW{1'b0}};
      end else begin
         key_valid_r <= accept_s;
         if (accept_s) begin
            key_code_r <= digit_s;
         end
         if (accept_s && clear_value) begin
            value_r <= VW'(digit_s);
         end else if (accept_s) begin
            value_r <= {value_r[VW-5:0], digit_s};
         end else if (clear_value) begin
            value_r <= {VW{1'b0}};
         end
      end
   end

   assign col_out   = col_r;
   assign key_valid = key_valid_r;
   assign key_code  = key_code_r;
   assign value_out = value_r;

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Scoreboard bench for hex_keypad_scanner: stimulus pushes expected accepts,
// a monitor pops and compares on every key_valid pulse.
module tb_hex_keypad_scanner;

   logic        system_clock = 1'b0;
   logic        cpu_rst;
   logic        clock_enable;
   logic [3:0]  row_in;
   logic        clear_value;
   logic [3:0]  col_out;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [31:0] value_out;

   logic [15:0] key_mask;
   logic [31:0] model_val;
   int checks = 0;
   int errors = 0;
   int edge_cnt = 0;
   int last_pulse_tick = -1;
   int first_seen;

   typedef struct {
      logic [3:0]  code;
      logic [31:0] val;
   } exp_t;
   exp_t exp_q[$];
   exp_t mon_e;

   always #5 system_clock = ~system_clock;

   hex_keypad_scanner #(.DEBOUNCE_SCANS(4), .NUM_DIGITS(8)) dut (
      .system_clock (system_clock),
      .cpu_rst      (cpu_rst),
      .clock_enable (clock_enable),
      .row_in       (row_in),
      .clear_value  (clear_value),
      .col_out      (col_out),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .value_out    (value_out)
   );

   // Passive keypad: a pressed key pulls its row low while its column is driven low
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (key_mask[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   always @(posedge system_clock)
      if (clock_enable && !cpu_rst) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every key_valid pulse must match the oldest expected accept
   always @(negedge system_clock) begin
      if (key_valid === 1'b1) begin
         last_pulse_tick = edge_cnt - 1;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_key_valid code=%h value=%h", key_code, value_out);
         end else begin
            mon_e = exp_q.pop_front();
            chk("key_code", {28'd0, key_code}, {28'd0, mon_e.code});
            chk("value_out", value_out, mon_e.val);
         end
      end
   end

   function automatic int key_pos(input logic [3:0] d);
      case (d)
         4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
         4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
         4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
         4'h0: return 12; 4'hF: return 13; 4'hE: return 14; 4'hD: return 15;
         default: return 0;
      endcase
   endfunction

   task automatic do_tick(input logic clr);
      repeat (3) @(negedge system_clock);
      clock_enable = 1'b1;
      clear_value  = clr;
      @(negedge system_clock);
      clock_enable = 1'b0;
      clear_value  = 1'b0;
   endtask

   task automatic wait_col(input int c);
      int n = 0;
      while (col_out[c] !== 1'b0 && n < 8) begin
         do_tick(1'b0);
         n++;
      end
      if (col_out[c] !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL wait_col_timeout actual=%b required_low_col=%0d", col_out, c);
      end
   endtask

   task automatic press(input logic [3:0] d);
      exp_t e;
      model_val = {model_val[27:0], d};
      e.code = d;
      e.val  = model_val;
      exp_q.push_back(e);
      key_mask = 16'd1 << key_pos(d);
      repeat (10) do_tick(1'b0);
      key_mask = 16'd0;
      repeat (6) do_tick(1'b0);
   endtask

   task automatic pulse_clear();
      @(negedge system_clock);
      clear_value = 1'b1;
      @(negedge system_clock);
      clear_value = 1'b0;
      model_val = 32'd0;
   endtask

   initial begin
      exp_t e;
      cpu_rst = 1'b1;
      clock_enable = 1'b0;
      clear_value = 1'b0;
      key_mask = 16'd0;
      model_val = 32'd0;
      repeat (2) @(negedge system_clock);
      chk("reset_col", {28'd0, col_out}, 32'h0000000E);
      chk("reset_valid", {31'd0, key_valid}, 32'd0);
      chk("reset_code", {28'd0, key_code}, 32'd0);
      chk("reset_value", value_out, 32'd0);
      cpu_rst = 1'b0;

      do_tick(1'b0);
      chk("col_rotate1", {28'd0, col_out}, 32'h0000000D);
      do_tick(1'b0);
      chk("col_rotate2", {28'd0, col_out}, 32'h0000000B);
      repeat (6) @(negedge system_clock);
      chk("col_hold_no_ce", {28'd0, col_out}, 32'h0000000B);

      // Key 5 held 10 ticks: one pulse three ticks after first sighting
      e.code = 4'h5; e.val = 32'h00000005; exp_q.push_back(e);
      model_val = 32'h5;
      key_mask = 16'd1 << key_pos(4'h5);
      first_seen = -1;
      for (int i = 0; i < 10; i++) begin
         if (first_seen < 0 && col_out[1] == 1'b0) first_seen = edge_cnt;
         do_tick(1'b0);
      end
      key_mask = 16'd0;
      repeat (6) do_tick(1'b0);
      chk("key5_latency", last_pulse_tick, first_seen + 3);
      chk("key5_value", value_out, 32'h00000005);

      pulse_clear();
      chk("clear_value", value_out, 32'd0);
      press(4'h1); press(4'hA); press(4'h0); press(4'hD);
      chk("seq_1A0D", value_out, 32'h00001A0D);

      // Bounce on key 9: two ticks low, one high, two low (column has moved on)
      wait_col(2);
      key_mask = 16'd1 << key_pos(4'h9);
      repeat (2) do_tick(1'b0);
      key_mask = 16'd0;
      do_tick(1'b0);
      key_mask = 16'd1 << key_pos(4'h9);
      repeat (2) do_tick(1'b0);
      key_mask = 16'd0;
      chk("bounce_col", {28'd0, col_out}, 32'h0000000D);
      do_tick(1'b0);
      chk("bounce_rotate", {28'd0, col_out}, 32'h0000000B);
      chk("bounce_value", value_out, 32'h00001A0D);

      pulse_clear();
      for (int d = 1; d <= 9; d++) press(4'(d));
      chk("nine_digits", value_out, 32'h23456789);

      // Clear coincident with accept of F (fourth tick after first sighting)
      wait_col(1);
      e.code = 4'hF; e.val = 32'h0000000F; exp_q.push_back(e);
      model_val = 32'hF;
      key_mask = 16'd1 << key_pos(4'hF);
      repeat (3) do_tick(1'b0);
      do_tick(1'b1);
      chk("clear_accept", value_out, 32'h0000000F);
      repeat (3) do_tick(1'b0);
      key_mask = 16'd0;
      repeat (6) do_tick(1'b0);

      // Ghosting: keys 1 and 4 share column 0
      key_mask = (16'd1 << key_pos(4'h1)) | (16'd1 << key_pos(4'h4));
      repeat (10) do_tick(1'b0);
      key_mask = 16'd0;
      repeat (2) do_tick(1'b0);
      chk("ghost_value", value_out, 32'h0000000F);
      press(4'hE);
      chk("after_ghost_E", value_out, 32'h000000FE);

      // Async reset mid-debounce, key still held afterwards
      wait_col(0);
      key_mask = 16'd1 << key_pos(4'h7);
      repeat (2) do_tick(1'b0);
      #2 cpu_rst = 1'b1;
      #1;
      chk("midrst_col", {28'd0, col_out}, 32'h0000000E);
      chk("midrst_valid", {31'd0, key_valid}, 32'd0);
      chk("midrst_value", value_out, 32'd0);
      chk("midrst_code", {28'd0, key_code}, 32'd0);
      @(negedge system_clock);
      cpu_rst = 1'b0;
      e.code = 4'h7; e.val = 32'h00000007; exp_q.push_back(e);
      model_val = 32'h7;
      repeat (10) do_tick(1'b0);
      key_mask = 16'd0;
      repeat (6) do_tick(1'b0);
      chk("redetect_value", value_out, 32'h00000007);

      repeat (5) @(negedge system_clock);
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
- Input-side counterpart of the multiplexed seven-segment display driver.
- The display driver scans anodes outward; this block scans the columns of a 4x4 hex keypad and reads the rows back.
- It debounces presses, decodes each key to a 4-bit hex digit, and shifts the digit into a 32-bit value register. That register feeds the display controller's value2disp input directly.
- Scanning advances on the same slow clock_enable tick used by the display refresh.

Parameters:
- DEBOUNCE_SCANS, 4: consecutive matching samples (clock_enable ticks) needed to accept a press or a release; legal range 1..15.
- NUM_DIGITS, 8: hex digits held in value_out; value_out width = 4*NUM_DIGITS.

Ports:
- system_clock  in  1  system clock
- cpu_rst  in  1  asynchronous reset, active-high
- clock_enable  in  1  one-cycle scan tick; all FSM and scan activity advances only on cycles where it is high
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to system_clock
- clear_value  in  1  synchronous clear of value_out
- col_out  out  4  column drive, one-hot-low
- key_valid  out  1  one system_clock pulse per accepted key
- key_code  out  4  hex value of the last accepted key
- value_out  out  4*NUM_DIGITS  entered digits, newest in [3:0]

Behaviour:
- Reset values (async, cpu_rst=1):
  - col_out=4'b1110, key_valid=0, key_code=0, value_out=0
  - FSM=SCAN, debounce counter=0, row synchroniser flops=4'hF
- Synchronisation: row_in passes through a 2-flop synchroniser on system_clock. All "row" references below mean the synchronised value.
- Sampling on each clock_enable: rows are sampled against the col_out value driven since the previous tick, giving one full tick of settle time.
- Valid press: exactly one row bit low. Zero or more than one low = no key (multi-key ghosting is ignored).
- Key map, row r / col c (col0 = col_out[0]):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM (transitions only on clock_enable):
  - SCAN, no valid press: rotate col_out left, wrapping 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - SCAN, valid press: latch row/col, counter=1, hold col_out, go to DEBOUNCE. If DEBOUNCE_SCANS==1, accept immediately instead.
  - DEBOUNCE: same single row low -> counter+1; on reaching DEBOUNCE_SCANS, accept and go to WAIT_RELEASE. Any other row pattern -> counter=0, rotate col_out, go to SCAN.
  - WAIT_RELEASE: rows all high -> counter+1; on reaching DEBOUNCE_SCANS go to SCAN and rotate col_out. Any low row -> counter=0.
- Accept, registered on the accepting clock_enable edge:
  - key_valid=1 for exactly one system_clock cycle
  - key_code=decoded digit
  - value_out={value_out[4*NUM_DIGITS-5:0], digit}; the oldest digit is discarded
- Latency: press first seen on tick n is accepted on tick n+DEBOUNCE_SCANS-1. A held key produces exactly one key_valid; no auto-repeat.
- clear_value: value_out=0 on the next edge. If it coincides with an accept, value_out={0..., digit}. key_code is unaffected by clear_value.
- clock_enable low: all state, outputs and counters hold; key_valid still self-clears after one cycle.
- Reset mid-debounce or mid-hold: immediate return to reset values. A key still held after reset is re-detected from SCAN as a new press.
- Counter saturates; it never wraps.

Decomposition:
- Package keypad_pkg holds:
  - enum scan_state_t {SCAN, DEBOUNCE, WAIT_RELEASE}
  - COL_INIT = 4'b1110
  - ROWS_IDLE = 4'hF
- Sub-module keypad_decoder: combinational 2-bit row index + 2-bit col index -> 4-bit hex digit, per the key map above.
- Row synchroniser is inline.

Test Plan:
- Reset: assert cpu_rst mid-run -> col_out=1110, value_out=0, key_valid=0 immediately, without waiting for a clock edge.
- Key '5' (col1,row1) held 10 ticks, DEBOUNCE_SCANS=4 -> one key_valid pulse on tick n+3, key_code=5, value_out=32'h00000005.
- Keys 1, A, 0, D pressed and released in sequence -> value_out=32'h00001A0D, four key_valid pulses.
- Bounce: row low for 2 ticks, high, then low for 2 ticks -> no key_valid, FSM back in SCAN, col_out resumes rotating.
- Nine digits 1..9 -> value_out=32'h23456789. Then clear_value coincident with the accept of 'F' -> value_out=32'h0000000F.
- Two rows low in the same column (keys 1 and 4) -> no key_valid. Release, then press E alone -> key_code=E.
